// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: default source slots,
// index width, register-bus addresses and the fixed-priority encoder.
package irq_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned NSRC_MAX = 8;

  typedef enum logic [IDX_W-1:0] {
    SRC_VBL    = 3'd0,
    SRC_STAT   = 3'd1,
    SRC_TIMER  = 3'd2,
    SRC_SERIAL = 3'd3,
    SRC_JOYPAD = 3'd4
  } src_e;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  // Lowest set bit wins; an all-zero vector yields index 0.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NSRC_MAX-1:0] v);
    lowest_set = '0;
    for (int i = NSRC_MAX - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// Joypad debouncer: ORs the keys, samples them into a shift chain on each
// tick_en strobe and reports a stable level plus an ungated wake flag.
module irq_debounce
  import irq_pkg::*;
#(
  parameter int unsigned NKEY     = 4,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            tick_en,
  input  logic [NKEY-1:0] key,
  output logic            jp_lvl,
  output logic            wake
);

  logic                key_any;
  logic [DEBOUNCE-1:0] chain_q;

  assign key_any = |key;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let one stage race into the next.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      chain_q <= '0;
      wake    <= 1'b0;
    end else begin
      wake <= key_any;
      if (tick_en) chain_q <= {chain_q[DEBOUNCE-2:0], key_any};
    end
  end

  // Pressed only when both the newest and oldest samples agree.
  assign jp_lvl = chain_q[0] & chain_q[DEBOUNCE-1];

endmodule

// File: rtl/irq_ctrl_n.sv
// Parametrised interrupt controller: IF/IE registers, rising-edge capture of
// peripheral levels and the debounced joypad, fixed priority and bus reads.
module irq_ctrl_n
  import irq_pkg::*;
#(
  parameter int unsigned NSRC       = 5,
  parameter int unsigned NKEY       = 4,
  parameter int unsigned JP_IDX     = SRC_JOYPAD,
  parameter int unsigned DEBOUNCE   = 4,
  parameter bit          UNUSED_ONE = 1'b1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             tick_en,
  input  logic [NSRC-1:0]  src,
  input  logic [NKEY-1:0]  key,
  input  logic             wr_if,
  input  logic             wr_ie,
  input  logic             rd_if,
  input  logic             rd_ie,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  output logic             irq_req,
  output logic [IDX_W-1:0] irq_idx,
  output logic [NSRC-1:0]  irq_pend,
  output logic             wake
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NSRC) - 9'd1);
  localparam logic [7:0] IF_FILL  = UNUSED_ONE ? ~SRC_MASK : 8'h00;

  logic [NSRC-1:0] if_q, ie_q, src_q, if_next, edge_vec;
  logic            jp_lvl, jp_q;
  logic            rd_any, rd_q;
  logic            unused_wdata;

  assign unused_wdata = ^(wdata & ~SRC_MASK);

  irq_debounce #(
    .NKEY     (NKEY),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .nreset  (nreset),
    .tick_en (tick_en),
    .key     (key),
    .jp_lvl  (jp_lvl),
    .wake    (wake)
  );

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    edge_vec         = src & ~src_q;
    edge_vec[JP_IDX] = jp_lvl & ~jp_q;

    if_next = wr_if ? wdata[NSRC-1:0] : if_q;
    for (int i = 0; i < NSRC; i++) begin
      if (ack && ack_idx == IDX_W'(i)) if_next[i] = 1'b0;
    end
    // A fresh edge is ORed last so it survives a same-cycle clear.
    if_next = if_next | edge_vec;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      src_q <= '0;
      jp_q  <= 1'b0;
      if_q  <= '0;
      ie_q  <= '0;
    end else begin
      src_q <= src;
      jp_q  <= jp_lvl;
      if_q  <= if_next;
      if (wr_ie) ie_q <= wdata[NSRC-1:0];
    end
  end

  assign irq_pend = if_q & ie_q;
  assign irq_req  = |irq_pend;
  assign irq_idx  = lowest_set(8'(irq_pend));

  // rdata is captured on the first enabled cycle and frozen while the
  // enable stays high, so a flag landing mid-read cannot tear the value.
  assign rd_any = rd_if | rd_ie;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_q  <= 1'b0;
      rdata <= 8'h00;
    end else begin
      rd_q <= rd_any;
      if (!rd_any)   rdata <= 8'h00;
      else if (!rd_q) rdata <= rd_if ? (IF_FILL | 8'(if_q)) : 8'(ie_q);
    end
  end

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Directed bench for irq_ctrl_n with hand-computed expectations per step.
module tb_irq_ctrl_n;

  logic       clk = 1'b0;
  logic       nreset;
  logic       tick_en;
  logic [4:0] src;
  logic [3:0] key;
  logic       wr_if, wr_ie, rd_if, rd_ie;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic [2:0] ack_idx;
  logic       irq_req;
  logic [2:0] irq_idx;
  logic [4:0] irq_pend;
  logic       wake;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_ctrl_n dut (
    .clk      (clk),
    .nreset   (nreset),
    .tick_en  (tick_en),
    .src      (src),
    .key      (key),
    .wr_if    (wr_if),
    .wr_ie    (wr_ie),
    .rd_if    (rd_if),
    .rd_ie    (rd_ie),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .irq_req  (irq_req),
    .irq_idx  (irq_idx),
    .irq_pend (irq_pend),
    .wake     (wake)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_en = 1'b1;
    tick();
    tick_en = 1'b0;
    tick();
  endtask

  initial begin
    nreset = 1'b0; tick_en = 1'b0; src = '0; key = '0;
    wr_if = 1'b0; wr_ie = 1'b0; rd_if = 1'b0; rd_ie = 1'b0;
    wdata = '0; ack = 1'b0; ack_idx = '0;
    repeat (3) tick();
    check("rst_req",  8'(irq_req),  8'h00);
    check("rst_idx",  8'(irq_idx),  8'h00);
    check("rst_pend", 8'(irq_pend), 8'h00);
    check("rst_rdata", rdata,       8'h00);
    check("rst_wake", 8'(wake),     8'h00);

    // Source 2 held high, then enabled.
    nreset = 1'b1;
    src = 5'b00100;
    tick();
    wr_ie = 1'b1; wdata = 8'h04;
    tick();
    wr_ie = 1'b0;
    check("s2_req",  8'(irq_req),  8'h01);
    check("s2_idx",  8'(irq_idx),  8'h02);
    check("s2_pend", 8'(irq_pend), 8'h04);
    rd_if = 1'b1;
    tick();
    check("s2_rd_if", rdata, 8'hE4);
    rd_if = 1'b0;
    tick();
    check("rd_idle", rdata, 8'h00);

    // Clear IF, enable all, then simultaneous edges on 1 and 3.
    wr_if = 1'b1; wr_ie = 1'b1; wdata = 8'h1F;
    wdata = 8'h00; wr_ie = 1'b0;
    tick();
    wr_if = 1'b0; wr_ie = 1'b1; wdata = 8'h1F;
    tick();
    wr_ie = 1'b0;
    check("clr_pend", 8'(irq_pend), 8'h00);
    src = 5'b01010;
    tick();
    check("dual_idx",  8'(irq_idx),  8'h01);
    check("dual_pend", 8'(irq_pend), 8'h0A);
    ack = 1'b1; ack_idx = 3'd1;
    tick();
    check("ack1_idx", 8'(irq_idx), 8'h03);
    ack_idx = 3'd3;
    tick();
    ack = 1'b0;
    check("ack3_req", 8'(irq_req), 8'h00);
    check("ack3_idx", 8'(irq_idx), 8'h00);

    // Write-clear racing a new edge on bit 0.
    src = '0;
    tick();
    wr_if = 1'b1; wdata = 8'h01;
    tick();
    check("wr_if01", 8'(irq_pend), 8'h01);
    wdata = 8'h00; src = 5'b00001;
    tick();
    wr_if = 1'b0; src = '0;
    check("set_wins", 8'(irq_pend), 8'h01);
    ack = 1'b1; ack_idx = 3'd7;
    tick();
    check("ack_oob", 8'(irq_pend), 8'h01);
    ack_idx = 3'd0;
    tick();
    ack = 1'b0;
    check("ack0", 8'(irq_pend), 8'h00);

    // Joypad: short press rejected, long press accepted.
    key = 4'b0001;
    tick();
    check("wake_on", 8'(wake), 8'h01);
    repeat (2) pulse_tick();
    key = '0;
    tick();
    check("wake_off", 8'(wake), 8'h00);
    repeat (4) pulse_tick();
    check("jp_short", 8'(irq_pend), 8'h00);
    key = 4'b0001;
    repeat (3) pulse_tick();
    check("jp_3tick", 8'(irq_pend), 8'h00);
    pulse_tick();
    check("jp_4tick", 8'(irq_pend), 8'h10);
    check("jp_idx",   8'(irq_idx),  8'h04);
    key = '0; ack = 1'b1; ack_idx = 3'd4;
    tick();
    ack = 1'b0;
    check("jp_ack", 8'(irq_pend), 8'h00);
    repeat (4) pulse_tick();

    // Read capture holds while enable is high.
    rd_if = 1'b1;
    tick();
    check("rd_hold0", rdata, 8'hE0);
    src = 5'b00100;
    tick();
    check("rd_hold1", rdata, 8'hE0);
    tick();
    check("rd_hold2", rdata, 8'hE0);
    rd_if = 1'b0;
    tick();
    check("rd_drop", rdata, 8'h00);
    rd_if = 1'b1;
    tick();
    check("rd_again", rdata, 8'hE4);
    rd_if = 1'b0;
    tick();
    rd_if = 1'b1; rd_ie = 1'b1;
    tick();
    check("rd_both", rdata, 8'hE4);
    rd_if = 1'b0; rd_ie = 1'b0;
    tick();
    rd_ie = 1'b1;
    tick();
    check("rd_ie", rdata, 8'h1F);
    rd_ie = 1'b0;
    tick();

    // Asynchronous reset in the middle of a read and a debounce.
    wr_if = 1'b1; wdata = 8'h1F;
    tick();
    wr_if = 1'b0;
    check("pre_pend", 8'(irq_pend), 8'h1F);
    check("pre_idx",  8'(irq_idx),  8'h00);
    key = 4'b0010;
    pulse_tick();
    rd_if = 1'b1;
    tick();
    check("pre_rdata", rdata,    8'hFF);
    check("pre_wake",  8'(wake), 8'h01);
    #2;
    nreset = 1'b0;
    #1;
    check("ar_req",   8'(irq_req),  8'h00);
    check("ar_idx",   8'(irq_idx),  8'h00);
    check("ar_pend",  8'(irq_pend), 8'h00);
    check("ar_rdata", rdata,        8'h00);
    check("ar_wake",  8'(wake),     8'h00);
    src = '0; key = '0; rd_if = 1'b0;
    repeat (3) tick();
    nreset = 1'b1;
    repeat (3) tick();
    wr_ie = 1'b1; wdata = 8'h1F;
    tick();
    wr_ie = 1'b0;
    check("post_pend", 8'(irq_pend), 8'h00);
    rd_if = 1'b1;
    tick();
    check("post_rd_if", rdata, 8'hE0);
    rd_if = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
